// File: rtl/nco_quad_pkg.sv
// nco_quad_pkg: default widths, quadrant encoding and quarter-wave LUT entry generator
package nco_quad_pkg;
  localparam int ACC_W_DEF = 16;
  localparam int LUT_AW_DEF = 8;
  localparam int AMP_W_DEF = 12;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;
  function automatic int lut_entry(int j, int n, int max);
    return $rtoi(real'(max) * $sin(3.141592653589793 * real'(j) / real'(2 * n)) + 0.5);
  endfunction
endpackage

// File: rtl/nco_quad_if.sv
// nco_quad_if: config handshake (cfg_valid/cfg_ready offer of cfg_freq + cfg_phase words)
interface nco_quad_if #(parameter int ACC_W = nco_quad_pkg::ACC_W_DEF);
  logic cfg_valid;
  logic cfg_ready;
  logic [ACC_W-1:0] cfg_freq;
  logic [ACC_W-1:0] cfg_phase;
  modport master(output cfg_valid, cfg_freq, cfg_phase, input cfg_ready);
  modport slave(input cfg_valid, cfg_freq, cfg_phase, output cfg_ready);
endinterface

// File: rtl/nco_sine_lut.sv
// nco_sine_lut: phase top bits p_i/v_i in -> signed sample s_o/v_o two registered stages later
module nco_sine_lut import nco_quad_pkg::*; #(
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int AMP_W = AMP_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic v_i,
  input  logic [LUT_AW+1:0] p_i,
  output logic v_o,
  output logic signed [AMP_W-1:0] s_o
);
  localparam int N = 2**LUT_AW;
  localparam int MAX = 2**(AMP_W-1) - 1;
  logic [AMP_W-2:0] lut [0:N];
  for (genvar j = 0; j <= N; j++) begin : g_lut
    assign lut[j] = (AMP_W-1)'(lut_entry(j, N, MAX));
  end
  quad_e q;
  logic [LUT_AW-1:0] k;
  logic [LUT_AW:0] idx;
  logic [AMP_W-2:0] mag_q;
  logic neg_q, v1_q;
  assign q = quad_e'(p_i[LUT_AW+1:LUT_AW]);
  assign k = p_i[LUT_AW-1:0];
  assign idx = (q == Q1 || q == Q3) ? (LUT_AW+1)'(N) - {1'b0, k} : {1'b0, k};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1_q <= 1'b0;
      neg_q <= 1'b0;
      mag_q <= '0;
      v_o <= 1'b0;
      s_o <= '0;
    end else begin
      v1_q <= v_i;
      v_o <= v1_q;
      if (v_i) begin
        neg_q <= q == Q2 || q == Q3;
        mag_q <= lut[idx];
      end
      if (v1_q) s_o <= neg_q ? -$signed({1'b0, mag_q}) : $signed({1'b0, mag_q});
    end
endmodule

// File: rtl/nco_quad.sv
// nco_quad: quadrant NCO; en_i advances acc, cfg sets freq/phase, outputs i/q codes, sin/cos, out_valid, wrap
module nco_quad import nco_quad_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int AMP_W = AMP_W_DEF,
  parameter bit UPDATE_ON_WRAP = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  nco_quad_if.slave cfg,
  output logic i_code_o,
  output logic q_code_o,
  output logic signed [AMP_W-1:0] sin_o,
  output logic signed [AMP_W-1:0] cos_o,
  output logic out_valid_o,
  output logic wrap_o
);
  localparam int T = LUT_AW + 2;
  localparam int L = ACC_W - T;
  logic [ACC_W-1:0] acc_q, acc_d, freq_q, phase_q, sh_freq_q, sh_phase_q;
  logic [T-1:0] p_d, p_q, pc_d;
  logic pend_q, carry_d, apply_d, acc_v_q, p_v_q, sin_v, cos_v;
  assign {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, freq_q};
  assign cfg.cfg_ready = ~pend_q;
  assign apply_d = pend_q & (UPDATE_ON_WRAP ? (~en_i | carry_d) : 1'b1);
  // only the top T phase bits are kept; the low bits contribute just their carry
  assign p_d = acc_q[ACC_W-1 -: T] + phase_q[ACC_W-1 -: T] + T'(acc_q[L-1:0] > ~phase_q[L-1:0]);
  assign pc_d = {p_q[T-1 -: 2] + 2'd1, p_q[T-3:0]};
  assign out_valid_o = sin_v & cos_v;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q <= '0;
      freq_q <= '0;
      phase_q <= '0;
      sh_freq_q <= '0;
      sh_phase_q <= '0;
      pend_q <= 1'b0;
      wrap_o <= 1'b0;
      acc_v_q <= 1'b0;
      p_v_q <= 1'b0;
      p_q <= '0;
      i_code_o <= 1'b0;
      q_code_o <= 1'b0;
    end else begin
      if (cfg.cfg_valid && !pend_q) begin
        sh_freq_q <= cfg.cfg_freq;
        sh_phase_q <= cfg.cfg_phase;
        pend_q <= 1'b1;
      end else if (apply_d) begin
        freq_q <= sh_freq_q;
        phase_q <= sh_phase_q;
        pend_q <= 1'b0;
      end
      if (en_i) acc_q <= acc_d;
      wrap_o <= en_i & carry_d;
      acc_v_q <= en_i;
      p_v_q <= acc_v_q;
      if (acc_v_q) begin
        p_q <= p_d;
        i_code_o <= p_d[T-1];
        // MSB of p plus a quarter turn
        q_code_o <= p_d[T-1] ^ p_d[T-2];
      end
    end
  nco_sine_lut #(.LUT_AW(LUT_AW), .AMP_W(AMP_W)) u_sin (
    .clk(clk), .rst(rst), .v_i(p_v_q), .p_i(p_q), .v_o(sin_v), .s_o(sin_o)
  );
  nco_sine_lut #(.LUT_AW(LUT_AW), .AMP_W(AMP_W)) u_cos (
    .clk(clk), .rst(rst), .v_i(p_v_q), .p_i(pc_d), .v_o(cos_v), .s_o(cos_o)
  );
endmodule

// File: tb/tb_nco_quad.sv
// tb_nco_quad: directed checks of nco_quad in immediate-update and update-on-wrap modes
module tb_nco_quad;
  logic clk = 1'b0, rst = 1'b1, en0 = 1'b0, en1 = 1'b0;
  logic i0, q0, ov0, w0, i1, q1, ov1, w1;
  logic signed [11:0] s0, c0, s1, c1;
  int n_chk = 0, n_fail = 0;
  localparam int SIN_T [4] = '{2047, 0, -2047, 0};
  localparam int COS_T [4] = '{0, -2047, 0, 2047};
  localparam int I_T [4] = '{0, 1, 1, 0};
  localparam int Q_T [4] = '{1, 1, 0, 0};
  always #5 clk = ~clk;
  nco_quad_if #(16) if0 (), if1 ();
  nco_quad #(.UPDATE_ON_WRAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en_i(en0), .cfg(if0), .i_code_o(i0), .q_code_o(q0),
    .sin_o(s0), .cos_o(c0), .out_valid_o(ov0), .wrap_o(w0)
  );
  nco_quad #(.UPDATE_ON_WRAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en_i(en1), .cfg(if1), .i_code_o(i1), .q_code_o(q1),
    .sin_o(s1), .cos_o(c1), .out_valid_o(ov1), .wrap_o(w1)
  );
  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg0(logic [15:0] f, logic [15:0] p);
    if0.cfg_valid = 1'b1;
    if0.cfg_freq = f;
    if0.cfg_phase = p;
    step();
    if0.cfg_valid = 1'b0;
    step();
  endtask
  task automatic run4(bit inv);
    int sg = inv ? -1 : 1;
    en0 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("wrap c%0d", c), w0, c % 4 == 0);
      chk($sformatf("out_valid c%0d", c), ov0, c >= 4);
      if (c >= 2) begin
        chk($sformatf("i_code c%0d", c), i0, I_T[(c-2)%4] ^ inv);
        chk($sformatf("q_code c%0d", c), q0, Q_T[(c-2)%4] ^ inv);
      end
      if (c >= 4) begin
        chk($sformatf("sin c%0d", c), s0, sg * SIN_T[(c-4)%4]);
        chk($sformatf("cos c%0d", c), c0, sg * COS_T[(c-4)%4]);
      end
    end
  endtask
  function automatic int ref_s(int p);
    real s = 2047.0 * $sin(2.0 * 3.141592653589793 * real'((p & 16'hFFFF) >> 6) / 1024.0);
    return s >= 0.0 ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
  endfunction
  initial begin
    int p_exp, err, nv, pk, rng, bad_p;
    if0.cfg_valid = 1'b0; if0.cfg_freq = '0; if0.cfg_phase = '0;
    if1.cfg_valid = 1'b0; if1.cfg_freq = '0; if1.cfg_phase = '0;
    repeat (2) step();
    chk("rst ready0", if0.cfg_ready, 1); chk("rst ready1", if1.cfg_ready, 1);
    chk("rst i0", i0, 0); chk("rst q0", q0, 0); chk("rst sin0", s0, 0); chk("rst cos0", c0, 0);
    chk("rst ov0", ov0, 0); chk("rst wrap0", w0, 0); chk("rst i1", i1, 0); chk("rst q1", q1, 0);
    chk("rst sin1", s1, 0); chk("rst cos1", c1, 0); chk("rst ov1", ov1, 0); chk("rst wrap1", w1, 0);
    rst = 1'b0;
    step();
    cfg0(16'h4000, 16'h0000);
    run4(1'b0);
    en0 = 1'b0; step();
    chk("hold ov a", ov0, 1); chk("hold wrap a", w0, 0);
    en0 = 1'b1; step();
    chk("hold ov b", ov0, 1);
    step();
    chk("hold ov c", ov0, 1); chk("hold cos c", c0, 2047);
    step();
    chk("hold ov gap", ov0, 0); chk("hold cos gap", c0, 2047);
    step();
    chk("hold ov after", ov0, 1); chk("hold sin after", s0, 2047); chk("hold cos after", c0, 0);
    en0 = 1'b0;
    repeat (4) step();
    cfg0(16'h4000, 16'h8000);
    run4(1'b1);
    if0.cfg_valid = 1'b1; if0.cfg_freq = 16'h1000; if0.cfg_phase = 16'h0000;
    step();
    if0.cfg_valid = 1'b0;
    chk("pend ready0", if0.cfg_ready, 0);
    rst = 1'b1;
    #1;
    chk("arst ready0", if0.cfg_ready, 1); chk("arst i0", i0, 0); chk("arst q0", q0, 0);
    chk("arst sin0", s0, 0); chk("arst cos0", c0, 0); chk("arst ov0", ov0, 0); chk("arst wrap0", w0, 0);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("post-rst wrap c%0d", c), w0, 0);
      chk($sformatf("post-rst ready c%0d", c), if0.cfg_ready, 1);
      if (c >= 4) begin
        chk($sformatf("post-rst sin c%0d", c), s0, 0);
        chk($sformatf("post-rst cos c%0d", c), c0, 2047);
      end
    end
    en0 = 1'b0;
    if1.cfg_valid = 1'b1; if1.cfg_freq = 16'h1000; if1.cfg_phase = 16'h0000;
    step();
    if1.cfg_valid = 1'b0;
    step();
    chk("uow ready idle", if1.cfg_ready, 1);
    en1 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("uow wrap k%0d", k), w1, k == 16 || k == 24);
      chk($sformatf("uow ready k%0d", k), if1.cfg_ready, k < 5 || k >= 16);
      if (k == 4) begin if1.cfg_valid = 1'b1; if1.cfg_freq = 16'h2000; end
      if (k == 5) if1.cfg_freq = 16'h3000;
      if (k == 8) if1.cfg_valid = 1'b0;
    end
    en1 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cfg0(16'h0001, 16'h0000);
    en0 = 1'b1;
    p_exp = 1; err = 0; nv = 0; pk = 0; rng = 0; bad_p = -1;
    for (int n = 1; n <= 65539; n++) begin
      step();
      if (ov0) begin
        if (s0 !== ref_s(p_exp) || c0 !== ref_s(p_exp + 16'h4000)) begin
          err++;
          if (bad_p < 0) bad_p = p_exp & 16'hFFFF;
        end
        if (s0 == 2047) pk++;
        if (s0 < -2047) rng++;
        nv++;
        p_exp++;
      end
    end
    chk("sweep sample count", nv, 65536);
    chk($sformatf("sweep model errors (first p=%0d)", bad_p), err, 0);
    chk("sweep peak reached", pk > 0, 1);
    chk("sweep below -MAX", rng, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
